// File: rtl/adder_series_bcd.sv
// Series accumulator (sum i, i^2, 2i-1 or 2i for i = 1..n) with sequential double-dabble
// BCD conversion and active-low seven-segment output. Optional macro: LEADING_ZERO_BLANK_EN.
module adder_series_bcd #(
    parameter int N_W    = 6,
    parameter int DIGITS = 4,
    parameter int FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_a_p,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [N_W-1:0]        count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int SUM_W  = 3 * N_W;
    localparam int TICK_W = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam int CNT_W  = $clog2(SUM_W + 1);
    localparam int BCD_W  = 4 * DIGITS;

    function automatic logic [63:0] pow10_m1(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < d; k++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0]          MAX_VAL  = pow10_m1(DIGITS);
    localparam logic [BCD_W-1:0]     NINES    = {DIGITS{4'h9}};
    localparam logic [7*DIGITS-1:0]  ZERO_SEG = {DIGITS{7'b1000000}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ACCUM   = 3'd2,
        S_CONVERT = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    function automatic logic [6:0] seg7_f(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    function automatic logic [7*DIGITS-1:0] disp_f(input logic [BCD_W-1:0] b);
        logic [7*DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && (b[4*k +: 4] == 4'd0) && (k != 0)) begin
                r[7*k +: 7] = 7'h7F;
            end else begin
                lead        = 1'b0;
                r[7*k +: 7] = seg7_f(b[4*k +: 4]);
            end
`else
            r[7*k +: 7] = seg7_f(b[4*k +: 4]);
`endif
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = b[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t                 state_q;
    logic [N_W-1:0]         n_q;
    logic [1:0]             mode_q;
    logic [SUM_W-1:0]       sum_q;
    logic [N_W-1:0]         i_q;
    logic [TICK_W-1:0]      tick_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [CNT_W-1:0]       conv_q;
    logic                   overflow_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7*DIGITS-1:0]    seg_q;

    logic [SUM_W-1:0]       i_ext_s;
    logic [SUM_W-1:0]       term_s;
    logic                   step_s;
    logic                   ovf_s;
    logic [BCD_W-1:0]       bcd_shift_s;

    // Series term, step strobe, range check and next double-dabble value
    always_comb begin
        i_ext_s = SUM_W'(i_q);
        case (mode_q)
            2'b00:   term_s = i_ext_s;
            2'b01:   term_s = i_ext_s * i_ext_s;
            2'b10:   term_s = (i_ext_s << 1) - SUM_W'(1'b1);
            2'b11:   term_s = i_ext_s << 1;
            default: term_s = i_ext_s;
        endcase
        step_s      = (tick_q == TICK_W'(FREQ - 1));
        ovf_s       = (64'(sum_q) > MAX_VAL);
        bcd_shift_s = {dd_adjust(bcd_q), sum_q[SUM_W-1]};
    end

    // Control FSM, accumulator, converter and registered outputs
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            mode_q     <= 2'b00;
            sum_q      <= '0;
            i_q        <= '0;
            tick_q     <= '0;
            bcd_q      <= '0;
            conv_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_q      <= ZERO_SEG;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    n_q    <= count;
                    mode_q <= mode;
                    sum_q  <= '0;
                    i_q    <= N_W'(1'b1);
                    tick_q <= '0;
                    bcd_q  <= '0;
                    conv_q <= '0;
                    if (count == '0) begin
                        state_q <= S_CONVERT;
                    end else begin
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (step_s) begin
                        tick_q <= '0;
                        sum_q  <= sum_q + term_s;
                        if (i_q == n_q) begin
                            state_q <= S_CONVERT;
                        end else begin
                            i_q <= i_q + N_W'(1'b1);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1'b1);
                    end
                end
                S_CONVERT: begin
                    // The range check must see the intact sum, i.e. before the first shift
                    if ((conv_q == '0) && ovf_s) begin
                        bcd_q      <= NINES;
                        seg_q      <= disp_f(NINES);
                        overflow_q <= 1'b1;
                        state_q    <= S_SHOW;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        sum_q  <= sum_q << 1;
                        bcd_q  <= bcd_shift_s;
                        conv_q <= conv_q + CNT_W'(1'b1);
                        if (conv_q == CNT_W'(SUM_W - 1)) begin
                            seg_q      <= disp_f(bcd_shift_s);
                            overflow_q <= 1'b0;
                            state_q    <= S_SHOW;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= S_CONVERT;
                        end
                    end
                end
                S_SHOW: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_SHOW;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seg      = seg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adder_series_bcd.sv
// Directed bench for adder_series_bcd: one instance with FREQ=1, one with FREQ=4.
module tb_adder_series_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en4;
    logic [1:0]  mode1, mode4;
    logic [5:0]  cnt1, cnt4;
    logic [27:0] seg1, seg4;
    logic        busy1, done1, ovf1;
    logic        busy4, done4, ovf4;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [27:0] prev_disp1;

    localparam logic [27:0] ZERO_SEG = {4{7'b1000000}};

    always #5 clk = ~clk;

    adder_series_bcd #(.N_W(6), .DIGITS(4), .FREQ(1)) u_dut (
        .clk(clk), .rst_a_p(rst), .enable(en1), .mode(mode1), .count(cnt1),
        .seg(seg1), .busy(busy1), .done(done1), .overflow(ovf1)
    );

    adder_series_bcd #(.N_W(6), .DIGITS(4), .FREQ(4)) u_dut4 (
        .clk(clk), .rst_a_p(rst), .enable(en4), .mode(mode4), .count(cnt4),
        .seg(seg4), .busy(busy4), .done(done4), .overflow(ovf4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a} patterns
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] exp_seg(input logic [15:0] bcd);
        logic [27:0] r;
        logic [3:0]  d;
`ifdef LEADING_ZERO_BLANK_EN
        logic        lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int k = 3; k >= 0; k--) begin
            d = bcd[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && d == 4'd0 && k != 0) begin
                r[7*k +: 7] = 7'b1111111;
            end else begin
                lead = 1'b0;
                r[7*k +: 7] = seg_of(d);
            end
`else
            r[7*k +: 7] = seg_of(d);
`endif
        end
        return r;
    endfunction

    task automatic run1(input string tag, input logic [1:0] m, input logic [5:0] c,
                        input logic [15:0] exp_bcd, input logic exp_ovf,
                        input int exp_lat, input bit pulse, input int hold);
        int cyc;
        @(negedge clk);
        en1 = 1'b1; mode1 = m; cnt1 = c;
        @(negedge clk);
        check_eq({tag, "_busy_start"}, 32'(busy1), 32'd1);
        check_eq({tag, "_seg_kept"}, 32'(seg1), 32'(prev_disp1));
        if (pulse) en1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_lat != 0) check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_done"}, 32'(done1), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy1), 32'd0);
        check_eq({tag, "_ovf"}, 32'(ovf1), 32'(exp_ovf));
        check_eq({tag, "_seg"}, 32'(seg1), 32'(exp_seg(exp_bcd)));
        prev_disp1 = exp_seg(exp_bcd);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check_eq({tag, "_hold_done"}, 32'(done1), 32'd1);
            check_eq({tag, "_hold_busy"}, 32'(busy1), 32'd0);
        end
        en1 = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle_done"}, 32'(done1), 32'd0);
        check_eq({tag, "_idle_seg"}, 32'(seg1), 32'(prev_disp1));
    endtask

    initial begin
        int cyc;
        rst = 1'b1; en1 = 1'b0; en4 = 1'b0;
        mode1 = 2'b00; mode4 = 2'b00; cnt1 = '0; cnt4 = '0;
        prev_disp1 = ZERO_SEG;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", 32'(busy1), 32'd0);
        check_eq("reset_done", 32'(done1), 32'd0);
        check_eq("reset_ovf", 32'(ovf1), 32'd0);
        check_eq("reset_seg", 32'(seg1), 32'(ZERO_SEG));
        rst = 1'b0;

        // 1+2+3+4+5 = 15; units digit 5 lights a,c,d,f,g
        run1("sum_i_5", 2'b00, 6'd5, 16'h0015, 1'b0, 25, 1'b1, 0);
        check_eq("sum_i_5_digit0", 32'(seg1[6:0]), 32'(7'b0010010));
        run1("sq_5", 2'b01, 6'd5, 16'h0055, 1'b0, 0, 1'b0, 0);
        run1("odd_10", 2'b10, 6'd10, 16'h0100, 1'b0, 0, 1'b0, 0);
        run1("even_63", 2'b11, 6'd63, 16'h4032, 1'b0, 0, 1'b0, 50);
        // 63*64*127/6 = 85344 does not fit four digits
        run1("sq_63_ovf", 2'b01, 6'd63, 16'h9999, 1'b1, 66, 1'b0, 0);

        // Reset between clock edges while accumulating
        @(negedge clk);
        en1 = 1'b1; mode1 = 2'b00; cnt1 = 6'd20;
        repeat (6) @(negedge clk);
        check_eq("rst_pre_busy", 32'(busy1), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_busy", 32'(busy1), 32'd0);
        check_eq("rst_mid_ovf", 32'(ovf1), 32'd0);
        check_eq("rst_mid_seg", 32'(seg1), 32'(ZERO_SEG));
        prev_disp1 = ZERO_SEG;
        @(negedge clk);
        rst = 1'b0; en1 = 1'b0;
        @(negedge clk);
        check_eq("rst_after_busy", 32'(busy1), 32'd0);

        run1("sum_i_3", 2'b00, 6'd3, 16'h0006, 1'b0, 0, 1'b1, 0);
        run1("odd_0", 2'b10, 6'd0, 16'h0000, 1'b0, 20, 1'b0, 0);

        // FREQ=4: LOAD, 3 steps x 4 cycles, 18 shifts; inputs change mid-run
        @(negedge clk);
        en4 = 1'b1; mode4 = 2'b00; cnt4 = 6'd3;
        cyc = 0;
        while (!done4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                cnt4 = 6'd9; mode4 = 2'b01;
            end
        end
        check_eq("f4_latency", 32'(cyc), 32'd32);
        check_eq("f4_done", 32'(done4), 32'd1);
        check_eq("f4_ovf", 32'(ovf4), 32'd0);
        check_eq("f4_seg", 32'(seg4), 32'(exp_seg(16'h0006)));
        en4 = 1'b0;
        @(negedge clk);
        check_eq("f4_idle_done", 32'(done4), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
